// File: rtl/simple_uart_rx.sv
// rtl/simple_uart_rx.sv - 8N1 serial receiver with valid strobe, pending/ack handshake, framing and overrun flags
module simple_uart_rx #(
  parameter int CLKS_PER_BIT = 2500,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_24MHz,
  input  logic       rst,
  input  logic       serial,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       pending,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shreg_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          pending_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          busy_q;

  logic          sync1_q;
  logic          rx_s_q;
  logic          rx_p_q;

  logic          good_byte;
  logic          pending_d;
  logic          overrun_d;

  // Two-flop synchronizer plus one-cycle history; preset high so reset release never looks like a start edge
  always_ff @(posedge clk_24MHz or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      sync1_q <= serial;
      rx_s_q  <= sync1_q;
      rx_p_q  <= rx_s_q;
    end
  end

  // A good byte completes at mid-stop-bit when the line reads high
  assign good_byte = (state_q == S_STOP) && (cnt_q == BIT_LAST) && rx_s_q;

  // Handshake next state: a new byte wins over a simultaneous ack, and only an unacked collision is an overrun
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (good_byte) begin
      pending_d = 1'b1;
      if (pending_q && !ack) begin
        overrun_d = 1'b1;
      end else if (ack) begin
        overrun_d = 1'b0;
      end
    end else if (ack) begin
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Frame FSM with registered outputs; STOP exits at mid-bit so a following start edge is never missed
  always_ff @(posedge clk_24MHz or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      pending_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      case (state_q)
        S_IDLE: begin
          if (rx_p_q && !rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            shreg_q <= {rx_s_q, shreg_q[7:1]};
            cnt_q   <= '0;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (rx_s_q) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign pending   = pending_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_simple_uart_rx.sv
// tb/tb_simple_uart_rx.sv - self-checking bench for simple_uart_rx
module tb_simple_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic       clk_24MHz = 1'b0;
  logic       rst       = 1'b1;
  logic       serial    = 1'b1;
  logic       ack       = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       pending;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int valid_cnt = 0;
  int fe_cnt = 0;
  int busy_cycles = 0;
  int last_valid_cycle = 0;
  int fall_cycle = 0;
  logic [7:0] got_q[$];
  logic       ovr_q[$];

  simple_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_24MHz(clk_24MHz),
    .rst(rst),
    .serial(serial),
    .ack(ack),
    .data(data),
    .valid(valid),
    .pending(pending),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk_24MHz = ~clk_24MHz;

  always @(posedge clk_24MHz) cycle++;

  always @(negedge clk_24MHz) begin
    if (!rst) begin
      if (valid) begin
        valid_cnt++;
        last_valid_cycle = cycle;
        got_q.push_back(data);
        ovr_q.push_back(overrun);
      end
      if (frame_err) fe_cnt++;
      if (busy) busy_cycles++;
    end
  end

  task automatic send_bit(input logic b);
    serial = b;
    repeat (CPB) @(negedge clk_24MHz);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    fall_cycle = cycle + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    serial = 1'b1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk_24MHz);
    ack = 1'b0;
    @(negedge clk_24MHz);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_24MHz);
    checks++;
    if ({data, valid, pending, frame_err, overrun, busy} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b p=%b fe=%b ov=%b busy=%b, want all 0", data, valid, pending, frame_err, overrun, busy);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk_24MHz);
    checks++;
    if (busy !== 1'b0 || valid_cnt != 0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b valids=%0d, want 0 0", busy, valid_cnt);
    end
  endtask

  task automatic test_single_byte();
    int v0;
    int f0;
    int lat;
    v0 = valid_cnt;
    f0 = fe_cnt;
    send_frame(8'h41, 1'b1);
    repeat (4) @(negedge clk_24MHz);
    lat = last_valid_cycle - fall_cycle;
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL single_valid_count: got %0d, want 1", valid_cnt - v0);
    end
    checks++;
    if (data !== 8'h41) begin
      errors++;
      $display("FAIL single_data: got %h, want 41", data);
    end
    checks++;
    if (pending !== 1'b1 || fe_cnt != f0) begin
      errors++;
      $display("FAIL single_pending_fe: got p=%b fe=%0d, want p=1 fe=0", pending, fe_cnt - f0);
    end
    checks++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      errors++;
      $display("FAIL single_latency: got %0d, want %0d +-1", lat, LAT);
    end
    pulse_ack();
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_clears: got pending=%b, want 0", pending);
    end
  endtask

  task automatic test_glitch();
    int v0;
    int f0;
    int b0;
    v0 = valid_cnt;
    f0 = fe_cnt;
    b0 = busy_cycles;
    serial = 1'b0;
    repeat (5) @(negedge clk_24MHz);
    serial = 1'b1;
    repeat (3 * CPB) @(negedge clk_24MHz);
    checks++;
    if (valid_cnt != v0 || fe_cnt != f0) begin
      errors++;
      $display("FAIL glitch_no_strobe: got valids=%0d fes=%0d, want 0 0", valid_cnt - v0, fe_cnt - f0);
    end
    checks++;
    if (busy !== 1'b0 || busy_cycles - b0 == 0 || busy_cycles - b0 >= CPB) begin
      errors++;
      $display("FAIL glitch_busy: got busy=%b busy_cycles=%0d, want 0 and 1..%0d", busy, busy_cycles - b0, CPB - 1);
    end
  endtask

  task automatic test_frame_error();
    int v0;
    int f0;
    v0 = valid_cnt;
    f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk_24MHz);
    checks++;
    if (fe_cnt - f0 != 1 || valid_cnt != v0) begin
      errors++;
      $display("FAIL ferr_strobe: got fes=%0d valids=%0d, want 1 0", fe_cnt - f0, valid_cnt - v0);
    end
    checks++;
    if (data !== 8'h41 || pending !== 1'b0) begin
      errors++;
      $display("FAIL ferr_data_held: got data=%h p=%b, want 41 0", data, pending);
    end
    send_frame(8'h42, 1'b1);
    repeat (4) @(negedge clk_24MHz);
    checks++;
    if (data !== 8'h42 || valid_cnt - v0 != 1 || fe_cnt - f0 != 1) begin
      errors++;
      $display("FAIL ferr_recover: got data=%h valids=%0d fes=%0d, want 42 1 1", data, valid_cnt - v0, fe_cnt - f0);
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[4];
    logic       exp_ovr;
    logic       m_pend;
    msg[0] = 8'h41;
    msg[1] = 8'h42;
    msg[2] = 8'h43;
    msg[3] = 8'h44;
    got_q.delete();
    ovr_q.delete();
    for (int i = 0; i < 4; i++) send_frame(msg[i], 1'b1);
    repeat (4) @(negedge clk_24MHz);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d, want 4", got_q.size());
    end
    m_pend = 1'b0;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      exp_ovr = m_pend;
      m_pend  = 1'b1;
      checks++;
      if (got_q[i] !== msg[i] || ovr_q[i] !== exp_ovr) begin
        errors++;
        $display("FAIL b2b_byte%0d: got data=%h ov=%b, want %h %b", i, got_q[i], ovr_q[i], msg[i], exp_ovr);
      end
    end
    checks++;
    if (data !== 8'h44 || overrun !== 1'b1 || pending !== 1'b1) begin
      errors++;
      $display("FAIL b2b_final: got data=%h ov=%b p=%b, want 44 1 1", data, overrun, pending);
    end
    pulse_ack();
    checks++;
    if (overrun !== 1'b0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack: got ov=%b p=%b, want 0 0", overrun, pending);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int v0;
    int f0;
    b = 8'h43;
    serial = 1'b0;
    repeat (CPB) @(negedge clk_24MHz);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    serial = b[4];
    repeat (HALF) @(negedge clk_24MHz);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({data, valid, pending, frame_err, overrun, busy} !== 13'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got data=%h v=%b p=%b fe=%b ov=%b busy=%b, want all 0", data, valid, pending, frame_err, overrun, busy);
    end
    serial = 1'b1;
    repeat (3) @(negedge clk_24MHz);
    rst = 1'b0;
    v0 = valid_cnt;
    f0 = fe_cnt;
    repeat (2 * CPB) @(negedge clk_24MHz);
    checks++;
    if (valid_cnt != v0 || fe_cnt != f0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: got valids=%0d fes=%0d busy=%b, want 0 0 0", valid_cnt - v0, fe_cnt - f0, busy);
    end
    send_frame(8'h44, 1'b1);
    repeat (4) @(negedge clk_24MHz);
    checks++;
    if (data !== 8'h44 || valid_cnt - v0 != 1 || fe_cnt != f0) begin
      errors++;
      $display("FAIL midreset_resume: got data=%h valids=%0d fes=%0d, want 44 1 0", data, valid_cnt - v0, fe_cnt - f0);
    end
    pulse_ack();
  endtask

  task automatic test_ack_with_valid();
    logic [7:0] b1;
    logic [7:0] b2;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    send_frame(b1, 1'b1);
    repeat (2) @(negedge clk_24MHz);
    fork
      send_frame(b2, 1'b1);
      begin
        repeat (LAT) @(negedge clk_24MHz);
        ack = 1'b1;
        @(negedge clk_24MHz);
        ack = 1'b0;
      end
    join
    repeat (4) @(negedge clk_24MHz);
    checks++;
    if (last_valid_cycle - fall_cycle != LAT) begin
      errors++;
      $display("FAIL ackv_alignment: got valid at +%0d, want +%0d", last_valid_cycle - fall_cycle, LAT);
    end
    checks++;
    if (pending !== 1'b1 || overrun !== 1'b0 || data !== b2) begin
      errors++;
      $display("FAIL ackv_state: got p=%b ov=%b data=%h, want 1 0 %h", pending, overrun, data, b2);
    end
    pulse_ack();
  endtask

  task automatic test_random();
    logic [7:0] exp_b[$];
    logic       exp_o[$];
    logic [7:0] b;
    logic [7:0] last_good;
    logic       stop;
    logic       m_pend;
    logic       m_ovr;
    int         f0;
    int         exp_fe;
    int         gap;
    got_q.delete();
    ovr_q.delete();
    f0 = fe_cnt;
    exp_fe = 0;
    m_pend = 1'b0;
    m_ovr = 1'b0;
    last_good = data;
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      if (stop) begin
        exp_b.push_back(b);
        if (m_pend) m_ovr = 1'b1;
        m_pend = 1'b1;
        exp_o.push_back(m_ovr);
        last_good = b;
      end else begin
        exp_fe++;
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        m_pend = 1'b0;
        m_ovr  = 1'b0;
      end
      gap = $urandom_range(0, 2);
      repeat (gap * CPB) @(negedge clk_24MHz);
    end
    repeat (4) @(negedge clk_24MHz);
    checks++;
    if (got_q.size() != exp_b.size() || fe_cnt - f0 != exp_fe) begin
      errors++;
      $display("FAIL rand_counts: got valids=%0d fes=%0d, want %0d %0d", got_q.size(), fe_cnt - f0, exp_b.size(), exp_fe);
    end
    for (int i = 0; i < exp_b.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_b[i] || ovr_q[i] !== exp_o[i]) begin
        errors++;
        $display("FAIL rand_byte%0d: got data=%h ov=%b, want %h %b", i, got_q[i], ovr_q[i], exp_b[i], exp_o[i]);
      end
    end
    checks++;
    if (data !== last_good || pending !== m_pend || overrun !== m_ovr) begin
      errors++;
      $display("FAIL rand_final: got data=%h p=%b ov=%b, want %h %b %b", data, pending, overrun, last_good, m_pend, m_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_midframe();
    test_ack_with_valid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_uart_rx.md
Name: simple_uart_rx

Overview:
- Serial receiver for the diy-UART link; the downstream consumer of the simpleUARTtx line output.
- Recovers 8N1 frames, LSB first, from an asynchronous serial input.
- Presents each byte with a one-cycle valid strobe plus a pending/ack handshake toward a sink, e.g. a string compare or echo logic.
- Flags framing errors and overruns; clocked from the main 24 MHz clock, no separate baud clock.

Parameters:
- CLKS_PER_BIT, 2500: main clocks per bit; 24 MHz / 9600 baud. Minimum 4.
- HALF_BIT, CLKS_PER_BIT/2 (floor): clocks from start-edge detection to start-bit mid-sample.

Ports:
- clk_24MHz  input  1  main clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial  input  1  serial line; idle high; asynchronous to clk_24MHz.
- ack  input  1  sink has consumed data; clears pending and overrun.
- data  output  8  last good received byte; held until the next good byte.
- valid  output  1  one-cycle strobe when data updates.
- pending  output  1  unacknowledged byte present in data.
- frame_err  output  1  one-cycle strobe on a bad stop bit.
- overrun  output  1  sticky: a good byte arrived while pending was set without ack.
- busy  output  1  receiver not in IDLE.

Behaviour:
- Reset (async, any state):
  - state=IDLE; counters 0; shift register 0.
  - data=0x00; valid, pending, frame_err, overrun, busy all 0.
  - Synchronizer flops and previous-sample register preset to 1 (idle line), so no false edge at reset release.
- Input conditioning:
  - serial passes through 2 flops to give rx_s; rx_p is rx_s delayed one cycle.
  - All decisions use rx_s only.
- bit_cnt counts 0..CLKS_PER_BIT-1; width = clog2(CLKS_PER_BIT). bit_idx is 3 bits.
- FSM states IDLE, START, DATA, STOP; busy=1 in all states except IDLE.
- IDLE:
  - On rx_p=1 and rx_s=0 (falling edge): go to START, bit_cnt=0.
  - A line held low (break) does not retrigger; a high is required first.
- START: increment bit_cnt. At bit_cnt==HALF_BIT-1:
  - rx_s=0: go to DATA, bit_cnt=0, bit_idx=0.
  - rx_s=1: glitch; go to IDLE. No strobe, no flag.
- DATA: increment bit_cnt. At bit_cnt==CLKS_PER_BIT-1 (mid-bit):
  - shreg = {rx_s, shreg[7:1]}; bit_cnt=0.
  - bit_idx==7: go to STOP. Otherwise bit_idx+1.
- STOP: increment bit_cnt. At bit_cnt==CLKS_PER_BIT-1, go to IDLE, and:
  - rx_s=1: data=shreg, valid=1 for exactly one cycle.
  - rx_s=0: frame_err=1 for one cycle; data, valid and pending unchanged.
- Handshake (registered, same edge as valid):
  - pending sets on valid, clears on ack.
  - valid and ack in the same cycle: pending stays 1, no overrun.
  - valid while pending=1 and ack=0: overrun=1 (sticky); data still takes the new byte.
  - ack clears overrun and pending.
  - ack with pending=0 has no effect.
- Latency: valid asserts 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±1) after the serial falling edge; STOP returns to IDLE at mid-stop-bit.
- Back-to-back frames:
  - IDLE is reached at mid-stop-bit, so a start edge arriving at the stop-bit end is caught.
  - Frames with zero idle gap are received without loss.
- Reset asserted mid-frame aborts the frame with no strobe. After release, reception resumes at the next falling edge that follows a high.

Test Plan:
1. CLKS_PER_BIT=16; send 0x41 as an 8N1 frame → exactly one valid pulse 2+8+144 (±1) cycles after the start edge; data=0x41, pending=1, frame_err=0; ack then clears pending.
2. serial low for 5 clocks, then high → returns to IDLE; busy seen high only briefly; no valid, no frame_err.
3. Send 0x55 with stop bit = 0, then line high, then 0x42 → frame_err pulse, data stays at its prior value, no valid; 0x42 then received correctly.
4. Send "ABCD" (0x41–0x44) back-to-back with zero gap and no ack → four valid pulses; overrun=1 after 0x42; final data=0x44; ack clears overrun and pending.
5. Assert rst during bit 4 of 0x43 → all outputs 0 immediately (async); after release, 0x44 is received correctly with no spurious strobe.
6. Pulse ack in the same cycle as the valid for the second byte → pending=1, overrun=0.
